// File: rtl/elixirchip_es1_spu_op_arbiter.sv
// Round-robin arbiter sharing one pipelined SPU op unit between NUM_REQ
// requesters. Results return tagged with the owning requester id.
module elixirchip_es1_spu_op_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 1,
  parameter int DATA_BITS = 8,
  parameter int ID_BITS   = $clog2(NUM_REQ)
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic                           cke,
  input  logic [NUM_REQ*DATA_BITS-1:0]   s_data,
  input  logic [NUM_REQ-1:0]             s_clear,
  input  logic [NUM_REQ-1:0]             s_valid,
  output logic [NUM_REQ-1:0]             s_ready,
  output logic [DATA_BITS-1:0]           m_op_data,
  output logic                           m_op_clear,
  output logic                           m_op_valid,
  input  logic [DATA_BITS-1:0]           s_op_data,
  output logic [DATA_BITS-1:0]           m_data,
  output logic [ID_BITS-1:0]             m_id,
  output logic                           m_clear,
  output logic                           m_valid,
  output logic                           m_busy
);

  localparam int unsigned NREQ_U   = NUM_REQ;
  localparam int          CNT_BITS = $clog2(LATENCY + 3);

  typedef struct packed {
    logic               valid;
    logic [ID_BITS-1:0] id;
    logic               clear;
  } tag_t;

  logic [ID_BITS-1:0]   ptr_q, ptr_d;
  logic [DATA_BITS-1:0] op_data_q, op_data_d;
  logic                 op_clear_q, op_clear_d;
  logic                 op_valid_q, op_valid_d;
  tag_t                 tag_q [LATENCY+1];
  tag_t                 tag_d [LATENCY+1];
  logic [DATA_BITS-1:0] res_data_q, res_data_d;
  logic [ID_BITS-1:0]   res_id_q, res_id_d;
  logic                 res_clear_q, res_clear_d;
  logic                 res_valid_q, res_valid_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   req;
  logic                 gnt_found;
  logic [ID_BITS-1:0]   gnt_id;
  logic [ID_BITS-1:0]   cand;
  logic [DATA_BITS-1:0] gnt_data;
  logic                 gnt_clear;
  int unsigned          ptr_u;
  int unsigned          idx;

  // Round-robin search upward from ptr for the first requester
  always_comb begin
    req       = s_valid | s_clear;
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    idx       = 0;
    ptr_u     = 32'(ptr_q);
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx  = (ptr_u + k) % NREQ_U;
      cand = ID_BITS'(idx);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    gnt_data  = s_data[gnt_id*DATA_BITS +: DATA_BITS];
    gnt_clear = s_clear[gnt_id];
    s_ready   = '0;
    if (cke && gnt_found && !reset) s_ready[gnt_id] = 1'b1;
  end

  // Next state: issue, tag pipeline, result capture and in-flight count
  always_comb begin
    ptr_d       = ptr_q;
    op_data_d   = op_data_q;
    op_clear_d  = op_clear_q;
    op_valid_d  = op_valid_q;
    tag_d       = tag_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_clear_d = res_clear_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    if (cke) begin
      op_clear_d = 1'b0;
      op_valid_d = 1'b0;
      if (gnt_found) begin
        ptr_d      = (32'(gnt_id) == NREQ_U - 1) ? '0 : gnt_id + 1'b1;
        op_data_d  = gnt_data;
        op_clear_d = gnt_clear;
        op_valid_d = ~gnt_clear;
      end
      tag_d[0] = '{valid: gnt_found, id: gnt_id, clear: gnt_clear};
      for (int unsigned i = 1; i <= LATENCY; i++) tag_d[i] = tag_q[i-1];
      res_valid_d = tag_q[LATENCY].valid;
      if (tag_q[LATENCY].valid) begin
        res_data_d  = s_op_data;
        res_id_d    = tag_q[LATENCY].id;
        res_clear_d = tag_q[LATENCY].clear;
      end
      if (gnt_found && !res_valid_q)      cnt_d = cnt_q + 1'b1;
      else if (!gnt_found && res_valid_q) cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers; reset wins over cke
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      op_data_q   <= '0;
      op_clear_q  <= 1'b0;
      op_valid_q  <= 1'b0;
      for (int unsigned i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_clear_q <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      op_data_q   <= op_data_d;
      op_clear_q  <= op_clear_d;
      op_valid_q  <= op_valid_d;
      tag_q       <= tag_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_clear_q <= res_clear_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_op_data  = op_data_q;
  assign m_op_clear = op_clear_q;
  assign m_op_valid = op_valid_q;
  assign m_data     = res_data_q;
  assign m_id       = res_id_q;
  assign m_clear    = res_clear_q;
  assign m_valid    = res_valid_q;
  assign m_busy     = (cnt_q != '0);

endmodule

// File: tb/tb_elixirchip_es1_spu_op_arbiter.sv
// Directed bench: three arbiters (LATENCY 0, 1, 8) share stimulus, each
// driving its own nop op unit model.
module tb_elixirchip_es1_spu_op_arbiter;

  logic        clk = 1'b0;
  logic        reset, cke;
  logic [31:0] s_data;
  logic [3:0]  s_clear, s_valid;

  logic [2:0][3:0] s_ready_w;
  logic [2:0][7:0] m_op_data_w, s_op_w, m_data_w;
  logic [2:0]      m_op_clear_w, m_op_valid_w, m_clear_w, m_valid_w, m_busy_w;
  logic [2:0][1:0] m_id_w;

  int lat [3] = '{0, 1, 8};
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_arbiter #(.NUM_REQ(4), .LATENCY(0), .DATA_BITS(8)) u_l0 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .s_ready(s_ready_w[0]), .m_op_data(m_op_data_w[0]),
    .m_op_clear(m_op_clear_w[0]), .m_op_valid(m_op_valid_w[0]), .s_op_data(s_op_w[0]),
    .m_data(m_data_w[0]), .m_id(m_id_w[0]), .m_clear(m_clear_w[0]),
    .m_valid(m_valid_w[0]), .m_busy(m_busy_w[0]));

  elixirchip_es1_spu_op_arbiter #(.NUM_REQ(4), .LATENCY(1), .DATA_BITS(8)) u_l1 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .s_ready(s_ready_w[1]), .m_op_data(m_op_data_w[1]),
    .m_op_clear(m_op_clear_w[1]), .m_op_valid(m_op_valid_w[1]), .s_op_data(s_op_w[1]),
    .m_data(m_data_w[1]), .m_id(m_id_w[1]), .m_clear(m_clear_w[1]),
    .m_valid(m_valid_w[1]), .m_busy(m_busy_w[1]));

  elixirchip_es1_spu_op_arbiter #(.NUM_REQ(4), .LATENCY(8), .DATA_BITS(8)) u_l8 (
    .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear),
    .s_valid(s_valid), .s_ready(s_ready_w[2]), .m_op_data(m_op_data_w[2]),
    .m_op_clear(m_op_clear_w[2]), .m_op_valid(m_op_valid_w[2]), .s_op_data(s_op_w[2]),
    .m_data(m_data_w[2]), .m_id(m_id_w[2]), .m_clear(m_clear_w[2]),
    .m_valid(m_valid_w[2]), .m_busy(m_busy_w[2]));

  // Nop op units: pass the operand through LATENCY cke-qualified stages
  logic [7:0] op1_q;
  logic [7:0] op8_q [8];
  always @(posedge clk) begin
    if (cke) begin
      op1_q    <= m_op_data_w[1];
      op8_q[0] <= m_op_data_w[2];
      for (int i = 1; i < 8; i++) op8_q[i] <= op8_q[i-1];
    end
  end
  assign s_op_w[0] = m_op_data_w[0];
  assign s_op_w[1] = op1_q;
  assign s_op_w[2] = op8_q[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cke = 1'b1; s_valid = '0; s_clear = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  logic [23:0] cke_pat;

  initial begin
    reset = 1'b1; cke = 1'b1; s_data = '0; s_clear = '0; s_valid = '0;
    tick();
    // requests during reset must not be accepted
    s_valid = 4'hf;
    #1;
    for (int n = 0; n < 3; n++) chk($sformatf("L%0d s_ready in reset", lat[n]), 32'(s_ready_w[n]), 0);
    tick();
    reset = 1'b0; s_valid = '0;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("L%0d rst m_valid", lat[n]), 32'(m_valid_w[n]), 0);
      chk($sformatf("L%0d rst m_busy", lat[n]), 32'(m_busy_w[n]), 0);
      chk($sformatf("L%0d rst m_op_valid", lat[n]), 32'(m_op_valid_w[n]), 0);
      chk($sformatf("L%0d rst m_data", lat[n]), 32'(m_data_w[n]), 0);
      chk($sformatf("L%0d rst m_id", lat[n]), 32'(m_id_w[n]), 0);
    end

    // Single request from requester 2
    s_valid = 4'b0100; s_data = 32'h005A0000;
    #1;
    chk("single s_ready", 32'(s_ready_w[1]), 32'h4);
    tick();
    s_valid = '0;
    chk("single m_op_valid", 32'(m_op_valid_w[1]), 1);
    chk("single m_op_clear", 32'(m_op_clear_w[1]), 0);
    chk("single m_op_data", 32'(m_op_data_w[1]), 32'h5A);
    chk("single m_busy", 32'(m_busy_w[1]), 1);
    tick();
    chk("single m_valid early", 32'(m_valid_w[1]), 0);
    tick();
    chk("single m_valid", 32'(m_valid_w[1]), 1);
    chk("single m_data", 32'(m_data_w[1]), 32'h5A);
    chk("single m_id", 32'(m_id_w[1]), 2);
    chk("single m_clear", 32'(m_clear_w[1]), 0);
    tick();
    chk("single m_valid drop", 32'(m_valid_w[1]), 0);
    chk("single m_data hold", 32'(m_data_w[1]), 32'h5A);
    chk("single m_busy idle", 32'(m_busy_w[1]), 0);

    // Continuous stream from all four, then idle until drained
    do_reset();
    s_data = 32'h44332211; s_valid = 4'hf;
    for (int k = 0; k < 28; k++) begin
      if (k == 14) s_valid = '0;
      #1;
      chk($sformatf("stream s_ready k%0d", k), 32'(s_ready_w[1]), (k < 14) ? (32'h1 << (k % 4)) : 0);
      for (int n = 0; n < 3; n++) begin
        int j, acc, dn;
        j   = k - lat[n] - 2;
        acc = (k < 14) ? k : 14;
        dn  = (j < 0) ? 0 : ((j > 14) ? 14 : j);
        chk($sformatf("L%0d stream m_valid k%0d", lat[n], k), 32'(m_valid_w[n]), (j >= 0 && j < 14) ? 1 : 0);
        chk($sformatf("L%0d stream m_busy k%0d", lat[n], k), 32'(m_busy_w[n]), (acc > dn) ? 1 : 0);
        if (j >= 0 && j < 14) begin
          chk($sformatf("L%0d stream m_id k%0d", lat[n], k), 32'(m_id_w[n]), 32'(j % 4));
          chk($sformatf("L%0d stream m_data k%0d", lat[n], k), 32'(m_data_w[n]), 32'h11 * 32'(j % 4 + 1));
        end else if (j >= 14) begin
          chk($sformatf("L%0d hold m_id k%0d", lat[n], k), 32'(m_id_w[n]), 1);
          chk($sformatf("L%0d hold m_data k%0d", lat[n], k), 32'(m_data_w[n]), 32'h22);
        end
      end
      tick();
    end

    // Clear takes priority over valid
    s_valid = 4'b0010; s_clear = 4'b0010; s_data = 32'h00007700;
    #1;
    chk("clear s_ready", 32'(s_ready_w[1]), 32'h2);
    tick();
    s_valid = '0; s_clear = '0;
    chk("clear m_op_clear", 32'(m_op_clear_w[1]), 1);
    chk("clear m_op_valid", 32'(m_op_valid_w[1]), 0);
    chk("clear m_op_data", 32'(m_op_data_w[1]), 32'h77);
    tick(); tick();
    chk("clear m_valid", 32'(m_valid_w[1]), 1);
    chk("clear m_clear", 32'(m_clear_w[1]), 1);
    chk("clear m_id", 32'(m_id_w[1]), 1);
    chk("clear m_data", 32'(m_data_w[1]), 32'h77);
    tick();

    // Stream under cke toggling: outputs follow the count of enabled cycles
    do_reset();
    cke_pat = 24'b1101_1011_0011_1011_0111_1011;
    s_data = 32'h44332211; s_valid = 4'hf;
    begin
      int e;
      e = 0;
      for (int k = 0; k < 24; k++) begin
        cke = cke_pat[k];
        #1;
        chk($sformatf("cke s_ready k%0d", k), 32'(s_ready_w[1]), cke ? (32'h1 << (e % 4)) : 0);
        for (int n = 0; n < 3; n++) begin
          int j;
          j = e - lat[n] - 2;
          chk($sformatf("L%0d cke m_valid k%0d", lat[n], k), 32'(m_valid_w[n]), (j >= 0) ? 1 : 0);
          if (j >= 0) begin
            chk($sformatf("L%0d cke m_id k%0d", lat[n], k), 32'(m_id_w[n]), 32'(j % 4));
            chk($sformatf("L%0d cke m_data k%0d", lat[n], k), 32'(m_data_w[n]), 32'h11 * 32'(j % 4 + 1));
          end
        end
        tick();
        if (cke) e++;
      end
    end
    cke = 1'b1; s_valid = '0;

    // Reset mid-stream after two accepts, ptr left non-zero
    do_reset();
    s_data = 32'h00323100; s_valid = 4'b0010;
    #1;
    chk("midrst s_ready a1", 32'(s_ready_w[1]), 32'h2);
    tick();
    s_valid = 4'b0100;
    #1;
    chk("midrst s_ready a2", 32'(s_ready_w[1]), 32'h4);
    tick();
    s_valid = '0; reset = 1'b1; cke = 1'b0;
    tick();
    chk("midrst m_op_valid", 32'(m_op_valid_w[1]), 0);
    chk("midrst m_busy", 32'(m_busy_w[1]), 0);
    cke = 1'b1; s_valid = 4'hf;
    #1;
    chk("midrst s_ready in reset", 32'(s_ready_w[1]), 0);
    tick();
    reset = 1'b0; s_valid = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("L%0d midrst m_valid k%0d", lat[n], k), 32'(m_valid_w[n]), 0);
        chk($sformatf("L%0d midrst m_busy k%0d", lat[n], k), 32'(m_busy_w[n]), 0);
      end
      tick();
    end
    s_valid = 4'hf;
    #1;
    chk("midrst next grant", 32'(s_ready_w[1]), 32'h1);
    tick();
    s_valid = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_arbiter.md
ELIXIRCHIP_ES1_SPU_OP_ARBITER -- requirements
Module: elixirchip_es1_spu_op_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- NUM_REQ, 4: number of requesters (2..16).
- LATENCY, 1: latency of the shared SPU op unit (0..16).
- DATA_BITS, 8: data width.
- ID_BITS, $clog2(NUM_REQ): requester-id width.
REQ-002 Ports SHALL be as follows, one per line.
- reset  in  1: synchronous reset, active-high.
- clk  in  1: single clock.
- cke  in  1: clock enable; all state advances only when 1.
- s_data  in  NUM_REQ x DATA_BITS: per-requester operand.
- s_clear  in  NUM_REQ: per-requester clear request.
- s_valid  in  NUM_REQ: per-requester data request.
- s_ready  out  NUM_REQ: request accepted this cycle.
- m_op_data  out  DATA_BITS: operand to the op unit.
- m_op_clear  out  1: clear to the op unit.
- m_op_valid  out  1: valid to the op unit.
- s_op_data  in  DATA_BITS: op unit result, LATENCY cycles after issue.
- m_data  out  DATA_BITS: returned result.
- m_id  out  ID_BITS: requester owning m_data.
- m_clear  out  1: returned result originates from a clear.
- m_valid  out  1: result strobe.
- m_busy  out  1: at least one operation in flight.

Function
REQ-003 Requester i SHALL request when s_valid[i] or s_clear[i] is 1; if both are 1, the operation is a clear.
REQ-004 At most one request SHALL be granted per cycle with cke=1, chosen round-robin starting at pointer ptr and searching upward modulo NUM_REQ.
REQ-005 s_ready[i] SHALL be combinational, equal to cke AND grant[i], and 0 for every requester when cke=0.
REQ-006 After a grant to i with cke=1, ptr SHALL become (i+1) mod NUM_REQ; with no grant, ptr SHALL hold.
REQ-007 Issue SHALL be registered, one cycle after the grant:
- m_op_data = granted s_data;
- m_op_clear = granted clear;
- m_op_valid = granted valid AND NOT clear.
With no grant, m_op_clear and m_op_valid SHALL be 0 and m_op_data SHALL hold its value.
REQ-008 A tag pipeline of LATENCY+1 stages SHALL carry {valid, id, clear}, advancing only on cke. It SHALL align each tag with s_op_data, sampling s_op_data in the cycle LATENCY cycles after m_op_* is asserted. With LATENCY=0, s_op_data is sampled in the same cycle as the issue.
REQ-009 At a valid aligned tag, m_data, m_id and m_clear SHALL register s_op_data, the tag id and the tag clear, and m_valid SHALL be 1 for exactly one cke cycle. Total latency from acceptance to m_valid is LATENCY+2 cke cycles.
REQ-010 When m_valid=0, m_data, m_id and m_clear SHALL hold their values.
REQ-011 An in-flight counter (0..LATENCY+2) SHALL behave as follows:
- increment on accept;
- decrement on m_valid;
- no change when both occur in the same cycle.
m_busy SHALL be (counter != 0).
REQ-012 Full throughput SHALL be sustained: one accept per cke cycle with no bubbles and no backpressure from the op unit.
REQ-013 When cke=0, ptr, all registers, the tag pipeline and the counter SHALL freeze, and m_valid SHALL hold its registered value.
REQ-014 Requests deasserting before a grant SHALL be dropped without side effects; requests are never queued internally.

Reset
REQ-015 On reset=1 at a clk edge, regardless of cke, the block SHALL set:
- ptr = 0;
- m_op_valid = m_op_clear = m_valid = m_clear = 0;
- m_op_data = m_data = 0;
- m_id = 0;
- tag pipeline invalid;
- counter = 0.
REQ-016 Operations in flight at reset SHALL be discarded, with no m_valid for them after reset deasserts.
REQ-017 While reset=1, s_ready SHALL be 0.

Verification
REQ-018 The bench SHALL cover these scenarios, with NUM_REQ=4, LATENCY=1 and a nop op unit unless stated otherwise.
- Single request: s_valid[2]=1, s_data[2]=0x5A for one cycle → s_ready[2]=1 that cycle; m_op_valid=1 with 0x5A next cycle; m_valid=1, m_data=0x5A, m_id=2 three cycles after acceptance.
- All four requesting continuously → grants 0,1,2,3,0,… with one per cycle; m_id returns 0,1,2,3 in order; m_busy stays 1.
- Clear priority: s_clear[1]=1 and s_valid[1]=1 → m_op_clear=1, m_op_valid=0; returned m_clear=1, m_id=1.
- cke toggling 1,0,1 during a stream → no s_ready while cke=0; results identical to the cke=1 run, delayed by the number of stall cycles.
- Reset mid-stream after 2 accepts → no m_valid afterwards; m_busy=0; the next grant goes to requester 0.
- LATENCY=0 and LATENCY=8: back-to-back accepts → m_valid exactly LATENCY+2 cycles after each accept; m_data stable between strobes.
